// File: rtl/mips_pipe_core.sv
// mips_pipe_core
// Five-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset pipeline with a unified
// word-addressed instruction/data memory and a 32x32 register file.
//
// Build option: define MUL_EN to build the multiplier for opcode 000101 (MUL).
// Without it, 000101 decodes as a NOP and no multiplier is built.
//
// Reg and Mem have no reset and are written from plain clocked processes, so
// a bench can preload them hierarchically while the core sits in reset.
module mips_pipe_core #(
    parameter int MEM_WORDS = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
`ifdef MUL_EN
    localparam logic [5:0] OP_MUL   = 6'b000101;
`endif
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Decoded instruction class. An all-zero value is a bubble / NOP.
    typedef struct packed {
        logic rr;     // register-register ALU op, dest rd
        logic ri;     // register-immediate ALU op, dest rt
        logic lw;
        logic sw;
        logic bnez;
        logic beqz;
        logic hlt;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: d.rr = 1'b1;
`ifdef MUL_EN
            OP_MUL:                                d.rr = 1'b1;
`endif
            OP_ADDI, OP_SUBI, OP_SLTI:             d.ri = 1'b1;
            OP_LW:                                 d.lw = 1'b1;
            OP_SW:                                 d.sw = 1'b1;
            OP_BNEQZ:                              d.bnez = 1'b1;
            OP_BEQZ:                               d.beqz = 1'b1;
            OP_HLT:                                d.hlt = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Architectural state (names fixed for hierarchical access)
    // ------------------------------------------------------------------
    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    logic [31:0] pc_d;
    logic        halted_d;
    logic        taken_branch_d;

    // IF/ID
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_ir_q,    ifid_ir_d;
    logic [31:0] ifid_npc_q,   ifid_npc_d;

    // ID/EX
    dec_t        idex_dec_q,   idex_dec_d;
    logic [5:0]  idex_op_q,    idex_op_d;
    logic [4:0]  idex_rs_q,    idex_rs_d;
    logic [4:0]  idex_rt_q,    idex_rt_d;
    logic [4:0]  idex_dst_q,   idex_dst_d;
    logic [31:0] idex_a_q,     idex_a_d;
    logic [31:0] idex_b_q,     idex_b_d;
    logic [31:0] idex_imm_q,   idex_imm_d;
    logic [31:0] idex_npc_q,   idex_npc_d;

    // EX/MEM
    dec_t        exmem_dec_q,  exmem_dec_d;
    logic [4:0]  exmem_dst_q,  exmem_dst_d;
    logic [31:0] exmem_alu_q,  exmem_alu_d;
    logic [31:0] exmem_b_q,    exmem_b_d;

    // MEM/WB
    dec_t        memwb_dec_q,  memwb_dec_d;
    logic [4:0]  memwb_dst_q,  memwb_dst_d;
    logic [31:0] memwb_alu_q,  memwb_alu_d;
    logic [31:0] memwb_lmd_q,  memwb_lmd_d;

    // Stage-local combinational signals
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    dec_t        id_dec;
    logic [31:0] id_a, id_b;
    logic [31:0] fwd_a, fwd_b;
    logic [31:0] alu_y;
    logic        ex_taken;
    logic        exm_fwd;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] fetch_word;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        freeze;

    assign halted = HALTED;

    // HLT in WB halts on this edge; once halted nothing moves again.
    assign freeze = HALTED | memwb_dec_q.hlt;

    // Write-back source, shared by the register write port, the
    // write-through read path and the MEM/WB forward path.
    assign wb_we   = (memwb_dec_q.rr | memwb_dec_q.ri | memwb_dec_q.lw) &&
                     (memwb_dst_q != 5'd0);
    assign wb_data = memwb_dec_q.lw ? memwb_lmd_q : memwb_alu_q;

    // Only ALU results are available in EX/MEM; load data arrives a stage later.
    assign exm_fwd = (exmem_dec_q.rr | exmem_dec_q.ri) && (exmem_dst_q != 5'd0);

    assign fetch_word = Mem[PC[AW-1:0]];
    assign mem_addr   = exmem_alu_q[AW-1:0];
    assign mem_rdata  = Mem[mem_addr];

    assign id_op = ifid_ir_q[31:26];
    assign id_rs = ifid_ir_q[25:21];
    assign id_rt = ifid_ir_q[20:16];
    assign id_rd = ifid_ir_q[15:11];

    // Address bits above the memory depth are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{PC[31:AW], exmem_alu_q[31:AW]};

    // ID: decode and register read with write-through from WB.
    always_comb begin
        id_dec = ifid_valid_q ? decode(id_op) : dec_t'('0);

        id_a = Reg[id_rs];
        if (id_rs == 5'd0)
            id_a = '0;
        else if (wb_we && (memwb_dst_q == id_rs))
            id_a = wb_data;

        id_b = Reg[id_rt];
        if (id_rt == 5'd0)
            id_b = '0;
        else if (wb_we && (memwb_dst_q == id_rt))
            id_b = wb_data;
    end

    // EX operand forwarding, EX/MEM (younger) before MEM/WB.
    always_comb begin
        fwd_a = idex_a_q;
        if (exm_fwd && (exmem_dst_q == idex_rs_q))
            fwd_a = exmem_alu_q;
        else if (wb_we && (memwb_dst_q == idex_rs_q))
            fwd_a = wb_data;

        fwd_b = idex_b_q;
        if (exm_fwd && (exmem_dst_q == idex_rt_q))
            fwd_b = exmem_alu_q;
        else if (wb_we && (memwb_dst_q == idex_rt_q))
            fwd_b = wb_data;
    end

    // EX: ALU, effective address and branch target share one result bus.
    always_comb begin
        alu_y = '0;
        case (idex_op_q)
            OP_ADD:          alu_y = fwd_a + fwd_b;
            OP_SUB:          alu_y = fwd_a - fwd_b;
            OP_AND:          alu_y = fwd_a & fwd_b;
            OP_OR:           alu_y = fwd_a | fwd_b;
            OP_SLT:          alu_y = {31'd0, $signed(fwd_a) < $signed(fwd_b)};
`ifdef MUL_EN
            // Low 32 bits of the product are the same signed or unsigned.
            OP_MUL:          alu_y = fwd_a * fwd_b;
`endif
            OP_LW, OP_SW,
            OP_ADDI:         alu_y = fwd_a + idex_imm_q;
            OP_SUBI:         alu_y = fwd_a - idex_imm_q;
            OP_SLTI:         alu_y = {31'd0, $signed(fwd_a) < $signed(idex_imm_q)};
            OP_BNEQZ,
            OP_BEQZ:         alu_y = idex_npc_q + idex_imm_q;
            default:         alu_y = '0;
        endcase

        ex_taken = (idex_dec_q.bnez && (fwd_a != 32'd0)) ||
                   (idex_dec_q.beqz && (fwd_a == 32'd0));
    end

    // Next-state for PC, flags and all pipeline latches.
    always_comb begin
        pc_d           = PC + 32'd1;
        halted_d       = freeze;
        taken_branch_d = 1'b0;

        ifid_valid_d = 1'b1;
        ifid_ir_d    = fetch_word;
        ifid_npc_d   = PC + 32'd1;

        idex_dec_d = id_dec;
        idex_op_d  = id_op;
        idex_rs_d  = id_rs;
        idex_rt_d  = id_rt;
        idex_dst_d = id_dec.rr ? id_rd : id_rt;
        idex_a_d   = id_a;
        idex_b_d   = id_b;
        idex_imm_d = {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};
        idex_npc_d = ifid_npc_q;

        exmem_dec_d = idex_dec_q;
        exmem_dst_d = idex_dst_q;
        exmem_alu_d = alu_y;
        exmem_b_d   = fwd_b;

        memwb_dec_d = exmem_dec_q;
        memwb_dst_d = exmem_dst_q;
        memwb_alu_d = exmem_alu_q;
        memwb_lmd_d = mem_rdata;

        if (freeze) begin
            // Everything younger than HLT is dropped and fetch stops.
            pc_d         = PC;
            ifid_valid_d = 1'b0;
            idex_dec_d   = '0;
            exmem_dec_d  = '0;
            memwb_dec_d  = '0;
        end else if (ex_taken) begin
            // The two instructions fetched behind the branch are squashed.
            pc_d           = alu_y;
            taken_branch_d = 1'b1;
            ifid_valid_d   = 1'b0;
            idex_dec_d     = '0;
        end
    end

    // Pipeline, PC and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_ir_q    <= '0;
            ifid_npc_q   <= '0;
            idex_dec_q   <= '0;
            idex_op_q    <= '0;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_dst_q   <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_imm_q   <= '0;
            idex_npc_q   <= '0;
            exmem_dec_q  <= '0;
            exmem_dst_q  <= '0;
            exmem_alu_q  <= '0;
            exmem_b_q    <= '0;
            memwb_dec_q  <= '0;
            memwb_dst_q  <= '0;
            memwb_alu_q  <= '0;
            memwb_lmd_q  <= '0;
        end else begin
            PC           <= pc_d;
            HALTED       <= halted_d;
            TAKEN_BRANCH <= taken_branch_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_ir_q    <= ifid_ir_d;
            ifid_npc_q   <= ifid_npc_d;
            idex_dec_q   <= idex_dec_d;
            idex_op_q    <= idex_op_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_dst_q   <= idex_dst_d;
            idex_a_q     <= idex_a_d;
            idex_b_q     <= idex_b_d;
            idex_imm_q   <= idex_imm_d;
            idex_npc_q   <= idex_npc_d;
            exmem_dec_q  <= exmem_dec_d;
            exmem_dst_q  <= exmem_dst_d;
            exmem_alu_q  <= exmem_alu_d;
            exmem_b_q    <= exmem_b_d;
            memwb_dec_q  <= memwb_dec_d;
            memwb_dst_q  <= memwb_dst_d;
            memwb_alu_q  <= memwb_alu_d;
            memwb_lmd_q  <= memwb_lmd_d;
        end
    end

    // Register write port (WB); no writes in reset or once halting.
    always @(posedge clk) begin
        if (rst_n && !freeze && wb_we)
            Reg[memwb_dst_q] <= wb_data;
    end

    // Data memory write port (SW in MEM); blocked behind a retiring HLT.
    always @(posedge clk) begin
        if (rst_n && !freeze && exmem_dec_q.sw)
            Mem[mem_addr] <= exmem_b_q;
    end

endmodule

// File: tb/tb_mips_pipe_core.sv
// tb_mips_pipe_core
// Directed programs with hand-computed results for mips_pipe_core.
// Expected MUL results follow the MUL_EN build option.
module tb_mips_pipe_core;

`ifdef MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    localparam logic [31:0] NOP_W = 32'hf800_0000;
    localparam logic [31:0] HLT_W = 32'hfc00_0000;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic halted;

    int n_vec = 0;
    int n_err = 0;
    int tb_rises;
    int tb_hi;
    int m198_changes;

    mips_pipe_core #(.MEM_WORDS(1024)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .halted (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic init_state();
        for (int i = 0; i < 256; i++) dut.Mem[i] = NOP_W;
        for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_factorial();
        dut.Mem[0]   = 32'h280a00c8;
        dut.Mem[1]   = 32'h28020001;
        dut.Mem[2]   = 32'h0e94a000;
        dut.Mem[3]   = 32'h21430000;
        dut.Mem[4]   = 32'h0e94a000;
        dut.Mem[5]   = 32'h14431000;
        dut.Mem[6]   = 32'h2c630001;
        dut.Mem[7]   = 32'h0e94a000;
        dut.Mem[8]   = 32'h3460fffc;
        dut.Mem[9]   = 32'h2542fffe;
        dut.Mem[10]  = 32'hfc000000;
        dut.Mem[200] = 32'd7;
    endtask

    // Run n clocks, tallying TAKEN_BRANCH pulses and changes of Mem[198].
    task automatic run(input int n);
        logic        tb_prev;
        logic [31:0] m_prev;
        tb_rises     = 0;
        tb_hi        = 0;
        m198_changes = 0;
        tb_prev      = 1'b0;
        m_prev       = dut.Mem[198];
        repeat (n) begin
            @(posedge clk);
            #1;
            if (dut.TAKEN_BRANCH) begin
                tb_hi++;
                if (!tb_prev) tb_rises++;
            end
            tb_prev = dut.TAKEN_BRANCH;
            if (dut.Mem[198] !== m_prev) m198_changes++;
            m_prev = dut.Mem[198];
        end
    endtask

    initial begin
        // ---- T1: reset state, simple immediates, halt freezes PC ----
        enter_reset();
        init_state();
        chk("rst_pc", dut.PC, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        dut.Mem[0] = 32'h280a00c8;
        dut.Mem[1] = 32'h28020001;
        dut.Mem[2] = HLT_W;
        leave_reset();
        run(20);
        chk("t1_r10", dut.Reg[10], 32'd200);
        chk("t1_r2", dut.Reg[2], 32'd1);
        chk("t1_r5", dut.Reg[5], 32'd5);
        chk("t1_halted", {31'd0, halted}, 32'd1);
        chk("t1_pc", dut.PC, 32'd6);
        run(5);
        chk("t1_pc_frozen", dut.PC, 32'd6);

        // ---- T2: forwarding paths and ALU ops ----
        enter_reset();
        init_state();
        dut.Mem[0]  = enc_i(OP_ADDI, 0, 1, 5);
        dut.Mem[1]  = enc_r(OP_ADD, 1, 1, 2);
        dut.Mem[2]  = enc_r(OP_SUB, 2, 1, 3);
        dut.Mem[3]  = enc_i(OP_SUBI, 0, 4, 3);
        dut.Mem[4]  = enc_r(OP_SLT, 4, 1, 5);
        dut.Mem[5]  = enc_i(OP_SLTI, 1, 6, -1);
        dut.Mem[6]  = enc_r(OP_AND, 2, 4, 7);
        dut.Mem[7]  = enc_r(OP_OR, 2, 1, 8);
        dut.Mem[8]  = enc_i(OP_SW, 0, 8, 100);
        dut.Mem[9]  = enc_i(OP_LW, 0, 9, 100);
        dut.Mem[10] = enc_r(OP_ADD, 0, 0, 0);
        dut.Mem[11] = enc_r(OP_ADD, 9, 9, 12);
        dut.Mem[12] = enc_i(OP_ADDI, 0, 0, 7);
        dut.Mem[13] = enc_r(OP_ADD, 0, 1, 13);
        dut.Mem[14] = HLT_W;
        leave_reset();
        run(40);
        chk("t2_r1", dut.Reg[1], 32'd5);
        chk("t2_r2_fwd", dut.Reg[2], 32'd10);
        chk("t2_r3_fwd", dut.Reg[3], 32'd5);
        chk("t2_r4_subi", dut.Reg[4], 32'hffff_fffd);
        chk("t2_r5_slt", dut.Reg[5], 32'd1);
        chk("t2_r6_slti", dut.Reg[6], 32'd0);
        chk("t2_r7_and", dut.Reg[7], 32'd8);
        chk("t2_r8_or", dut.Reg[8], 32'd15);
        chk("t2_mem100", dut.Mem[100], 32'd15);
        chk("t2_r9_lw", dut.Reg[9], 32'd15);
        chk("t2_r12_ldfwd", dut.Reg[12], 32'd30);
        chk("t2_r0", dut.Reg[0], 32'd0);
        chk("t2_r13_r0src", dut.Reg[13], 32'd5);
        chk("t2_pc", dut.PC, 32'd18);

        // ---- T3: factorial loop with taken-branch squash ----
        enter_reset();
        init_state();
        load_factorial();
        dut.Mem[198] = 32'd0;
        leave_reset();
        run(150);
        chk("t3_mem198", dut.Mem[198], MUL_ON ? 32'd5040 : 32'd1);
        chk("t3_mem200", dut.Mem[200], 32'd7);
        chk("t3_r3", dut.Reg[3], 32'd0);
        chk("t3_r2", dut.Reg[2], MUL_ON ? 32'd5040 : 32'd1);
        chk("t3_halted", {31'd0, halted}, 32'd1);
        chk("t3_pc", dut.PC, 32'd14);
        chk("t3_m198_writes", 32'(m198_changes), 32'd1);
        chk("t3_taken_pulses", 32'(tb_rises), 32'd6);
        chk("t3_taken_cycles", 32'(tb_hi), 32'd6);

        // ---- T4: taken BEQZ squashes two, not-taken BNEQZ is free ----
        enter_reset();
        init_state();
        dut.Mem[0] = enc_i(OP_BEQZ, 0, 0, 2);
        dut.Mem[1] = enc_i(OP_ADDI, 0, 5, 9);
        dut.Mem[2] = enc_i(OP_ADDI, 0, 6, 9);
        dut.Mem[3] = enc_i(OP_BNEQZ, 0, 0, 5);
        dut.Mem[4] = enc_i(OP_ADDI, 0, 7, 77);
        dut.Mem[5] = HLT_W;
        leave_reset();
        run(25);
        chk("t4_r5_squash", dut.Reg[5], 32'd5);
        chk("t4_r6_squash", dut.Reg[6], 32'd6);
        chk("t4_r7", dut.Reg[7], 32'd77);
        chk("t4_taken_pulses", 32'(tb_rises), 32'd1);
        chk("t4_taken_cycles", 32'(tb_hi), 32'd1);
        chk("t4_pc", dut.PC, 32'd9);

        // ---- T5: reset for one edge mid-loop, then a fresh program ----
        enter_reset();
        init_state();
        load_factorial();
        dut.Mem[198] = 32'd0;
        leave_reset();
        run(30);
        enter_reset();
        chk("t5_pc", dut.PC, 32'd0);
        chk("t5_HALTED", {31'd0, dut.HALTED}, 32'd0);
        chk("t5_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        chk("t5_r10_kept", dut.Reg[10], 32'd200);
        chk("t5_mem200_kept", dut.Mem[200], 32'd7);
        chk("t5_mem0_kept", dut.Mem[0], 32'h280a00c8);
        dut.Reg[2] = 32'h66;
        dut.Reg[3] = 32'h55;
        dut.Mem[0] = enc_i(OP_ADDI, 0, 11, 33);
        dut.Mem[1] = HLT_W;
        leave_reset();
        run(20);
        chk("t5_r11", dut.Reg[11], 32'd33);
        chk("t5_r2_untouched", dut.Reg[2], 32'h66);
        chk("t5_r3_untouched", dut.Reg[3], 32'h55);
        chk("t5_mem198", dut.Mem[198], 32'd0);
        chk("t5_halted", {31'd0, halted}, 32'd1);
        chk("t5_pc", dut.PC, 32'd5);

        // ---- T6: MUL present or decoded as NOP ----
        enter_reset();
        init_state();
        dut.Mem[0] = enc_r(OP_MUL, 2, 3, 2);
        dut.Mem[1] = enc_i(OP_ADDI, 2, 4, 1);
        dut.Mem[2] = enc_i(OP_SUBI, 0, 6, 4);
        dut.Mem[3] = enc_r(OP_MUL, 6, 3, 7);
        dut.Mem[4] = HLT_W;
        leave_reset();
        run(20);
        chk("t6_r2_mul", dut.Reg[2], MUL_ON ? 32'd6 : 32'd2);
        chk("t6_r4", dut.Reg[4], MUL_ON ? 32'd7 : 32'd3);
        chk("t6_r6", dut.Reg[6], 32'hffff_fffc);
        chk("t6_r7_mulneg", dut.Reg[7], MUL_ON ? 32'hffff_fff4 : 32'd7);
        chk("t6_halted", {31'd0, halted}, 32'd1);
        chk("t6_pc", dut.PC, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_pipe_core.md
Name: mips_pipe_core

Overview:
- Five-stage (IF, ID, EX, MEM, WB) 32-bit MIPS-subset pipeline with a unified word-addressed instruction/data memory and a 32x32 register file.
- Used as a standalone processor core.
- Benches preload `Reg`/`Mem` and read results hierarchically.
- Internal state names are fixed for hierarchical access: `Reg[0:31]`, `Mem[0:MEM_WORDS-1]`, `PC`, `HALTED`, `TAKEN_BRANCH`.

Parameters:
- MEM_WORDS, 1024, depth of the unified 32-bit memory. Addresses are word indices; the low log2(MEM_WORDS) bits are used.

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- halted  output  1  mirrors HALTED

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - PC=0, HALTED=0, TAKEN_BRANCH=0, all pipeline latches become bubbles, halted=0.
  - Reg and Mem are NOT reset; preloaded contents survive. Reset mid-run aborts all in-flight instructions.
- Encoding: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended.
- Register-register ops (dest rd):
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: signed, result 1/0.
  - MUL 000101.
- Register-immediate ops (dest rt):
  - LW 001000: rt=Mem[rs+imm].
  - SW 001001: Mem[rs+imm]=rt.
  - ADDI 001010, SUBI 001011, SLTI 001100.
- Branches, target = (branch PC+1)+imm:
  - BNEQZ 001101: taken if rs!=0.
  - BEQZ 001110: taken if rs==0.
- HLT 111111. Every other opcode is a NOP.
- Arithmetic is 32-bit with wraparound. MUL keeps the low 32 bits of the signed product. Writes to r0 are ignored, so r0 reads 0.
- Throughput is one instruction per clock with no structural stalls.
- Data hazards:
  - The register file is write-through: a WB write is visible to an ID read in the same cycle.
  - EX operands are forwarded from EX/MEM (ALU results) and MEM/WB (ALU or load data), with the youngest source winning.
  - No load-use interlock: software places at least one instruction between a LW and its consumer.
- Branches:
  - Resolved in EX.
  - If taken, the next edge loads PC=target, squashes IF/ID and ID/EX to bubbles, and sets TAKEN_BRANCH for exactly one cycle.
  - Squashed instructions never write Reg or Mem and never halt.
  - Not-taken branches incur no penalty.
- Halt:
  - HLT sets HALTED when it reaches WB.
  - While HALTED: PC frozen, no fetch, no Reg or Mem writes. Instructions younger than HLT are discarded.
  - Only reset clears HALTED.
- SW writes in MEM. LW reads in MEM, and its data is written in WB.

Optional Feature:
- MUL_EN defined: MUL (000101) is executed as specified.
- MUL_EN undefined:
  - No multiplier is built and opcode 000101 decodes as NOP: no register write.
  - All other behaviour is unchanged.

Test Plan:
- Reset then preload Reg[k]=k and run `ADDI r10,r0,200 / ADDI r2,r0,1 / HLT` -> r10=200, r2=1, halted=1, PC stops advancing.
- Back-to-back dependency, `ADDI r1,r0,5; ADD r2,r1,r1; SUB r3,r2,r1` -> r2=10, r3=5 via forwarding.
- With MUL_EN, factorial program:
  - Program: `Mem[0..10]=280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, fc000000`, with Mem[200]=7.
  - Run 150 clocks -> Mem[198]=5040, Mem[200]=7, r3=0, halted=1.
  - The SW/HLT behind each taken branch are squashed, so Mem[198] is written exactly once.
- Taken branch:
  - BEQZ r0,+2 followed by `ADDI r5,r0,9; ADDI r6,r0,9` -> r5 and r6 unchanged.
  - TAKEN_BRANCH pulses high for one cycle.
- Assert rst_n=0 for one edge mid-loop, then reload PC-relevant program -> pipeline empties, PC=0, HALTED=0, Reg/Mem preserved.
- Without MUL_EN, `MUL r2,r2,r3` -> r2 unchanged, and subsequent instructions execute normally.
